// File: rtl/quadra_sum_stage.sv
// rtl/quadra_sum_stage.sv - final sum/round/saturate stage of the quadratic approximation unit
module quadra_sum_stage #(
   parameter int A_W      = 24,
   parameter int T1_W     = 22,
   parameter int T2_W     = 18,
   parameter int FRAC_IN  = 20,
   parameter int Y_W      = 16,
   parameter int FRAC_OUT = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [A_W-1:0]  a_fxd,
   input  logic signed [T1_W-1:0] t1_fxd,
   input  logic signed [T2_W-1:0] t2_fxd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [Y_W-1:0]  y,
   output logic                   y_sat,
   input  logic                   sat_clr,
   output logic                   sat_sticky
);

   localparam int MAX_AT = (A_W > T1_W) ? A_W : T1_W;
   localparam int MAX_W  = (MAX_AT > T2_W) ? MAX_AT : T2_W;
   localparam int S_W    = MAX_W + 2;
   localparam int SH     = FRAC_IN - FRAC_OUT;

   localparam logic signed [S_W:0] HALF  = (S_W+1)'(1) <<< (SH - 1);
   localparam logic signed [S_W:0] Y_MAX = (S_W+1)'((2 ** (Y_W - 1)) - 1);
   localparam logic signed [S_W:0] Y_MIN = -Y_MAX - (S_W+1)'(1);

   generate
      if (FRAC_IN <= FRAC_OUT) begin : g_bad_frac
         $error("quadra_sum_stage: FRAC_IN must be greater than FRAC_OUT");
      end
   endgenerate

   logic                  adv;
   logic                  s1_valid;
   logic                  s2_valid;
   logic signed [S_W-1:0] s1_sum;
   logic signed [S_W-1:0] a_ext;
   logic signed [S_W-1:0] t1_ext;
   logic signed [S_W-1:0] t2_ext;
   logic signed [S_W-1:0] sum_c;
   logic signed [S_W:0]   biased_c;
   logic signed [S_W:0]   rnd_c;
   logic signed [Y_W-1:0] y_c;
   logic                  sat_c;

   // Both stages move together; an empty stage 2 always frees the pipe.
   assign adv       = !s2_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = s2_valid;

   assign a_ext  = S_W'(a_fxd);
   assign t1_ext = S_W'(t1_fxd);
   assign t2_ext = S_W'(t2_fxd);
   assign sum_c  = a_ext + t1_ext + t2_ext;

   // Half-up rounding: add half an output LSB, then floor via arithmetic shift.
   assign biased_c = (S_W+1)'(s1_sum) + HALF;
   assign rnd_c    = biased_c >>> SH;

   always_comb begin
      y_c   = rnd_c[Y_W-1:0];
      sat_c = 1'b0;
      if (rnd_c > Y_MAX) begin
         y_c   = Y_MAX[Y_W-1:0];
         sat_c = 1'b1;
      end else if (rnd_c < Y_MIN) begin
         y_c   = Y_MIN[Y_W-1:0];
         sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s2_valid <= 1'b0;
         y        <= '0;
         y_sat    <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_sum   <= sum_c;
         s2_valid <= s1_valid;
         y        <= y_c;
         y_sat    <= sat_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_sticky <= 1'b0;
      end else if (out_valid && out_ready && y_sat) begin
         sat_sticky <= 1'b1;
      end else if (sat_clr) begin
         sat_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quadra_sum_stage.sv
// tb/tb_quadra_sum_stage.sv - self-checking bench for quadra_sum_stage
module tb_quadra_sum_stage;

   localparam int A_W      = 24;
   localparam int T1_W     = 22;
   localparam int T2_W     = 18;
   localparam int FRAC_IN  = 20;
   localparam int Y_W      = 16;
   localparam int FRAC_OUT = 14;
   localparam int SH       = FRAC_IN - FRAC_OUT;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic signed [A_W-1:0]  a_fxd;
   logic signed [T1_W-1:0] t1_fxd;
   logic signed [T2_W-1:0] t2_fxd;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [Y_W-1:0]  y;
   logic                   y_sat;
   logic                   sat_clr;
   logic                   sat_sticky;

   quadra_sum_stage #(
      .A_W(A_W), .T1_W(T1_W), .T2_W(T2_W),
      .FRAC_IN(FRAC_IN), .Y_W(Y_W), .FRAC_OUT(FRAC_OUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_fxd(a_fxd), .t1_fxd(t1_fxd), .t2_fxd(t2_fxd),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_sat(y_sat),
      .sat_clr(sat_clr), .sat_sticky(sat_sticky)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_in  = 0;
   int n_out = 0;

   longint exp_y_q[$];
   bit     exp_s_q[$];
   bit     model_sticky = 1'b0;
   bit     hold_pending = 1'b0;
   longint hold_y;
   bit     hold_s;
   bit     drv_done;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Real-valued meaning: sum scaled by 2^-FRAC_IN, rounded half-up to 2^-FRAC_OUT, clamped.
   function automatic void ref_model(input longint a, input longint t1, input longint t2,
                                     output longint ry, output bit rs);
      longint sum, num, q, lim_hi, lim_lo;
      sum    = a + t1 + t2;
      num    = sum + (longint'(1) << (SH - 1));
      q      = num / (longint'(1) << SH);
      if (num < 0 && (num % (longint'(1) << SH)) != 0) q = q - 1;
      lim_hi = (longint'(1) << (Y_W - 1)) - 1;
      lim_lo = -(longint'(1) << (Y_W - 1));
      rs     = 1'b0;
      ry     = q;
      if (q > lim_hi) begin ry = lim_hi; rs = 1'b1; end
      if (q < lim_lo) begin ry = lim_lo; rs = 1'b1; end
   endfunction

   // Transfer monitor, sampled mid-cycle so the values seen are those the next edge will use.
   always @(negedge clk) begin
      longint ey;
      bit     es;
      if (!rst_n) begin
         exp_y_q.delete();
         exp_s_q.delete();
         model_sticky = 1'b0;
         hold_pending = 1'b0;
      end else begin
         check("in_ready", in_ready, !out_valid || out_ready);
         check("sat_sticky", sat_sticky, model_sticky);
         if (hold_pending && out_valid) begin
            check("hold_y", y, hold_y);
            check("hold_y_sat", y_sat, hold_s);
         end
         hold_pending = out_valid && !out_ready;
         hold_y       = y;
         hold_s       = y_sat;
         if (in_valid && in_ready) begin
            ref_model(a_fxd, t1_fxd, t2_fxd, ey, es);
            exp_y_q.push_back(ey);
            exp_s_q.push_back(es);
            n_in++;
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_y_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               ey = exp_y_q.pop_front();
               es = exp_s_q.pop_front();
               check("y", y, ey);
               check("y_sat", y_sat, es);
               if (es) model_sticky = 1'b1;
               else if (sat_clr) model_sticky = 1'b0;
            end
         end else if (sat_clr) begin
            model_sticky = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input longint a, input longint t1, input longint t2);
      bit acc;
      int n;
      n        = 0;
      a_fxd    = A_W'(a);
      t1_fxd   = T1_W'(t1);
      t2_fxd   = T2_W'(t2);
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 200);
      if (!acc) check("put_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic one(input string tag, input longint a, input longint t1, input longint t2,
                      input longint ey, input bit es);
      put(a, t1, t2);
      check({tag, "_lat1"}, out_valid, 0);
      tick();
      check({tag, "_lat2"}, out_valid, 1);
      check({tag, "_y"}, y, ey);
      check({tag, "_sat"}, y_sat, es);
      tick();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_y_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, exp_y_q.size(), 0);
   endtask

   task automatic rand_term(output longint a, output longint t1, output longint t2);
      a  = longint'($signed(A_W'($urandom))) >>> $urandom_range(0, 6);
      t1 = longint'($signed(T1_W'($urandom))) >>> $urandom_range(0, 4);
      t2 = longint'($signed(T2_W'($urandom)));
   endtask

   initial begin
      int base;
      longint ra, rt1, rt2;
      #200_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      longint ra, rt1, rt2;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a_fxd     = '0;
      t1_fxd    = '0;
      t2_fxd    = '0;
      out_ready = 1'b1;
      sat_clr   = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_y_sat", y_sat, 0);
      check("rst_sticky", sat_sticky, 0);
      rst_n = 1'b1;
      tick();

      one("unity", 1048576, 0, 0, 16384, 0);
      one("rnd_p32", 0, 32, 0, 1, 0);
      one("rnd_m32", 0, -32, 0, 0, 0);
      one("rnd_m33", 0, -33, 0, -1, 0);
      one("rnd_p31", 0, 31, 0, 0, 0);
      one("sat_hi", 8388607, 2097151, 131071, 32767, 1);
      check("sticky_set", sat_sticky, 1);
      one("sat_lo", -8388608, -2097152, -131072, -32768, 1);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check("sticky_clr", sat_sticky, 0);

      // Backpressure: six back-to-back sets, output stalled for three cycles.
      base     = n_out;
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               rand_term(ra, rt1, rt2);
               put(ra, rt1, rt2);
            end
         end
         begin
            repeat (2) tick();
            out_ready = 1'b0;
            repeat (3) tick();
            out_ready = 1'b1;
         end
      join
      drain("bp");
      check("bp_count", n_out - base, 6);

      // Reset with both stages full and the sticky bit set.
      one("pre_rst", 8388607, 0, 0, 32767, 1);
      check("pre_rst_sticky", sat_sticky, 1);
      out_ready = 1'b0;
      put(1048576, 0, 0);
      put(2097152, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_sticky", sat_sticky, 0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      one("post_rst", 1048576, 0, 0, 16384, 0);

      // Random traffic with random downstream readiness.
      base     = n_out;
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               rand_term(ra, rt1, rt2);
               put(ra, rt1, rt2);
               if ($urandom_range(0, 3) == 0) tick();
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               out_ready = ($urandom_range(0, 2) != 0);
               tick();
            end
            out_ready = 1'b1;
         end
      join
      drain("rand");
      check("rand_count", n_out - base, 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
